// File: rtl/spi_pkg.sv
// Shared SPI definitions for the flash interface blocks (spi_master and its receive-side companions).
package spi_pkg;

    localparam logic [7:0]  RDID_OPCODE     = 8'h9F;
    localparam logic [23:0] M25P16_JEDEC_ID = 24'h202015;

    // SPI mode 0: clock idles low, MISO sampled on the rising edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        CAPTURE
    } rdid_state_e;

endpackage

// File: rtl/spi_edge_detect.sv
// Registers the SPI clock (already synchronous to clk) and flags its rising and falling edges.
module spi_edge_detect #(
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk_i,
    output logic rise_o,
    output logic fall_o
);

    logic sclk_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_q <= IDLE_LEVEL;
        end else begin
            sclk_q <= sclk_i;
        end
    end

    assign rise_o = sclk_i & ~sclk_q;
    assign fall_o = ~sclk_i & sclk_q;

endmodule

// File: rtl/spi_rdid_capture.sv
// Passive SPI listener: skips the RDID opcode clocks, deserializes the JEDEC ID from MISO,
// and reports it with a valid strobe, an ID-match flag and a watchdog abort strobe.
module spi_rdid_capture
    import spi_pkg::*;
#(
    parameter int                        CMD_BITS       = 8,
    parameter int                        RESP_BYTES     = 3,
    parameter logic [8*RESP_BYTES-1:0]   EXPECTED_ID    = (8*RESP_BYTES)'(M25P16_JEDEC_ID),
    parameter int                        TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      get_rdid,
    input  logic                      SPICLK,
    input  logic                      SPIMISO,
    output logic [8*RESP_BYTES-1:0]   rdid,
    output logic                      rdid_valid,
    output logic                      rdid_match,
    output logic                      rdid_err,
    output logic                      busy
);

    localparam int N       = 8 * RESP_BYTES;
    localparam int CNT_MAX = (CMD_BITS > N) ? CMD_BITS : N;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int WD_W    = $clog2(TIMEOUT_CYCLES + 1);

    logic rise;
    logic fall;
    logic sample;

    spi_edge_detect #(
        .IDLE_LEVEL (SPI_CPOL)
    ) u_edge (
        .clk    (clk),
        .reset  (reset),
        .sclk_i (SPICLK),
        .rise_o (rise),
        .fall_o (fall)
    );

    assign sample = (SPI_CPHA == 1'b0) ? rise : fall;

    rdid_state_e        state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WD_W-1:0]    wd_q;
    logic [WD_W-1:0]    wd_d;
    logic [N-1:0]       shreg_q;
    logic [N-1:0]       shreg_d;
    logic [N-1:0]       rdid_q;
    logic               rdid_valid_q;
    logic               rdid_match_q;
    logic               rdid_err_q;
    logic               busy_q;
    logic               timeout;

    // Watchdog saturates; a value of 1 means "one cycle since the last edge or start".
    assign wd_d    = (wd_q == WD_W'(TIMEOUT_CYCLES)) ? wd_q : wd_q + WD_W'(1);
    assign timeout = (wd_d == WD_W'(TIMEOUT_CYCLES));
    assign shreg_d = {shreg_q[N-2:0], SPIMISO};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wd_q         <= '0;
            shreg_q      <= '0;
            rdid_q       <= '0;
            rdid_valid_q <= 1'b0;
            rdid_match_q <= 1'b0;
            rdid_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            rdid_valid_q <= 1'b0;
            rdid_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (get_rdid) begin
                        cnt_q   <= '0;
                        wd_q    <= WD_W'(1);
                        busy_q  <= 1'b1;
                        state_q <= SKIP;
                    end
                end
                SKIP: begin
                    if (sample) begin
                        wd_q <= WD_W'(1);
                        if (cnt_q == CNT_W'(CMD_BITS - 1)) begin
                            cnt_q   <= '0;
                            state_q <= CAPTURE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else if (timeout) begin
                        rdid_err_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        wd_q <= wd_d;
                    end
                end
                CAPTURE: begin
                    if (sample) begin
                        wd_q    <= WD_W'(1);
                        shreg_q <= shreg_d;
                        if (cnt_q == CNT_W'(N - 1)) begin
                            rdid_q       <= shreg_d;
                            rdid_match_q <= (shreg_d == EXPECTED_ID);
                            rdid_valid_q <= 1'b1;
                            busy_q       <= 1'b0;
                            state_q      <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else if (timeout) begin
                        rdid_err_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        wd_q <= wd_d;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rdid       = rdid_q;
    assign rdid_valid = rdid_valid_q;
    assign rdid_match = rdid_match_q;
    assign rdid_err   = rdid_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_spi_rdid_capture.sv
// Bench for spi_rdid_capture: directed RDID scenarios plus randomized frames, checked every cycle
// against a frame-level reference model.
module tb_spi_rdid_capture;

    localparam int          CMD_BITS    = 8;
    localparam int          RESP_BYTES  = 3;
    localparam int          N           = 8 * RESP_BYTES;
    localparam int          FRAME_RISES = CMD_BITS + N;
    localparam int          TIMEOUT     = 64;
    localparam logic [23:0] EXP_ID      = 24'h202015;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        get_rdid = 1'b0;
    logic        SPICLK = 1'b0;
    logic        SPIMISO = 1'b0;
    logic [23:0] rdid;
    logic        rdid_valid;
    logic        rdid_match;
    logic        rdid_err;
    logic        busy;

    always #5 clk = ~clk;

    spi_rdid_capture #(
        .CMD_BITS       (CMD_BITS),
        .RESP_BYTES     (RESP_BYTES),
        .EXPECTED_ID    (EXP_ID),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .get_rdid   (get_rdid),
        .SPICLK     (SPICLK),
        .SPIMISO    (SPIMISO),
        .rdid       (rdid),
        .rdid_valid (rdid_valid),
        .rdid_match (rdid_match),
        .rdid_err   (rdid_err),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle step: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: frame progress expressed as rise counts and the cycle of the last event.
    int          cyc = 0;
    logic        m_active = 1'b0;
    int          m_rises = 0;
    int          m_last = 0;
    logic [23:0] m_val = '0;
    logic [23:0] m_rdid = '0;
    logic        m_match = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_err = 1'b0;
    logic        m_prev = 1'b0;

    int n_valid_seen = 0;
    int n_err_seen = 0;
    int err_cyc = 0;
    int last_rise = 0;

    task automatic model(input logic g, input logic s, input logic m, input logic r);
        logic rise;
        rise    = s && !m_prev;
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (r) begin
            m_active = 1'b0;
            m_rdid   = '0;
            m_match  = 1'b0;
            m_prev   = 1'b0;
        end else begin
            if (!m_active) begin
                if (g) begin
                    m_active = 1'b1;
                    m_rises  = 0;
                    m_val    = '0;
                    m_last   = cyc;
                end
            end else if (rise) begin
                m_last  = cyc;
                m_rises = m_rises + 1;
                if (m_rises > CMD_BITS)
                    m_val = 24'((m_val * 2) + m);
                if (m_rises == FRAME_RISES) begin
                    m_rdid   = m_val;
                    m_match  = (m_val == EXP_ID);
                    m_valid  = 1'b1;
                    m_active = 1'b0;
                end
            end else if ((cyc + 1 - m_last) == TIMEOUT) begin
                m_err    = 1'b1;
                m_active = 1'b0;
            end
            m_prev = s;
        end
    endtask

    task automatic step(input logic g, input logic s, input logic m, input logic r);
        get_rdid = g;
        SPICLK   = s;
        SPIMISO  = m;
        reset    = r;
        model(g, s, m, r);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk("busy", 32'(busy), 32'(m_active));
        chk("rdid_valid", 32'(rdid_valid), 32'(m_valid));
        chk("rdid_err", 32'(rdid_err), 32'(m_err));
        chk("rdid", 32'(rdid), 32'(m_rdid));
        chk("rdid_match", 32'(rdid_match), 32'(m_match));
        if (rdid_valid === 1'b1) n_valid_seen++;
        if (rdid_err === 1'b1) begin
            n_err_seen++;
            err_cyc = cyc;
        end
    endtask

    // One RDID transaction; stop_at/retrig_at/rst_at are rise indices (-1 = unused).
    task automatic frame(input logic [23:0] id, input logic g_clk, input int stop_at,
                         input int retrig_at, input int rst_at);
        logic [7:0] op;
        logic       b;
        int         v0;
        int         e0;
        op = spi_pkg::RDID_OPCODE;
        v0 = n_valid_seen;
        e0 = n_err_seen;
        last_rise = cyc;
        step(1'b1, g_clk, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < FRAME_RISES; r++) begin
            if (r == stop_at) break;
            b = (r < CMD_BITS) ? op[3'(7 - r)] : id[5'(23 - (r - CMD_BITS))];
            last_rise = cyc;
            step(r == retrig_at, 1'b1, b, r == rst_at);
            step(1'b0, 1'b0, b, 1'b0);
        end
        if (stop_at >= 0) begin
            repeat (TIMEOUT + 6) step(1'b0, 1'b0, 1'b0, 1'b0);
            chk("timeout_pulses", 32'(n_err_seen - e0), 32'd1);
            chk("timeout_latency", 32'(err_cyc - last_rise), 32'(TIMEOUT));
        end else begin
            repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("valid_pulses", 32'(n_valid_seen - v0), (stop_at < 0 && rst_at < 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        logic [23:0] saved;
        logic [23:0] rid;
        int          stop_at;
        int          retrig_at;
        @(negedge clk);
        repeat (10) step(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);

        frame(24'h202015, 1'b0, -1, -1, -1);
        chk("nominal_match", 32'(rdid_match), 32'd1);
        frame(24'hEF4015, 1'b0, -1, -1, -1);
        chk("mismatch_rdid", 32'(rdid), 32'hEF4015);
        frame(24'h202015, 1'b0, -1, 11, -1);
        frame(24'hEF4015, 1'b0, -1, -1, CMD_BITS + 4);
        chk("reset_rdid", 32'(rdid), 32'd0);
        frame(24'h202015, 1'b0, -1, -1, -1);
        saved = rdid;
        frame(24'h123456, 1'b0, 10, -1, -1);
        chk("timeout_keeps_rdid", 32'(rdid), 32'(saved));

        for (int i = 0; i < 40; i++) step(1'b0, 1'(i % 2), 1'b1, 1'b0);
        chk("noise_rdid", 32'(rdid), 32'(saved));

        for (int k = 0; k < 12; k++) begin
            rid       = ($urandom_range(0, 2) == 0) ? EXP_ID : 24'($urandom);
            stop_at   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, FRAME_RISES - 1) : -1;
            retrig_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, FRAME_RISES - 1) : -1;
            frame(rid, 1'($urandom_range(0, 1)), stop_at, retrig_at, -1);
            if (stop_at < 0) chk("rand_rdid", 32'(rdid), 32'(rid));
            for (int j = 0; j < $urandom_range(0, 6); j++)
                step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_rdid_capture.md
# spi_rdid_capture

Receive-side companion to `spi_master`: it watches the same SPI bus the master drives and deserializes the flash's reply to an RDID (0x9F) command. After the 8 opcode clocks it shifts in the 3-byte JEDEC ID from SPIMISO, publishes it with a one-cycle valid strobe, and flags whether it matches the expected M25P16 ID. It sits between the SPI pins and the system-side status/control logic. It never drives the bus.

## Interface

- `CMD_BITS`, 8: SPICLK rising edges skipped (opcode phase) before capture starts.
- `RESP_BYTES`, 3: response bytes captured.
- `EXPECTED_ID`, 24'h202015: JEDEC ID compared against the capture (mfr 0x20, type 0x20, capacity 0x15).
- `TIMEOUT_CYCLES`, 64: maximum clk cycles allowed between SPICLK rising edges while busy.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `get_rdid` in 1: one-cycle start pulse. The same pulse also starts `spi_master`.
- `SPICLK` in 1: SPI clock produced by the master, synchronous to clk, period 2 clk cycles.
- `SPIMISO` in 1: flash serial data out.
- `rdid` out 8*RESP_BYTES: last captured ID, MSB first.
- `rdid_valid` out 1: one-cycle pulse; `rdid` and `rdid_match` are updated for that cycle.
- `rdid_match` out 1: `rdid == EXPECTED_ID`, held until the next capture completes.
- `rdid_err` out 1: one-cycle pulse when a capture is aborted by timeout.
- `busy` out 1: high while a capture is in progress.

## Operation

- **Edge detect:** register SPICLK into `spiclk_q`. `rise = SPICLK & ~spiclk_q`. SPI mode 0: MISO is sampled on the rising edge, with SPIMISO read in the same cycle as `rise`.
- **IDLE:** `busy=0`. Any `rise` is ignored. When `get_rdid=1`, clear the bit counter and the watchdog and go to SKIP.
- **SKIP:** `busy=1`. Count `rise` events. On the CMD_BITS-th rise, clear the counter and go to CAPTURE. MISO is not sampled during SKIP.
- **CAPTURE:** on each `rise`, `shreg <= {shreg[N-2:0], SPIMISO}` with N = 8*RESP_BYTES.
  - On the N-th rise: load `rdid <= {shreg[N-2:0], SPIMISO}`, load `rdid_match` from that same value, pulse `rdid_valid`, go to IDLE.
- **Watchdog:** counts clk cycles since the last `rise`, or since `get_rdid`, while in SKIP or CAPTURE.
  - When the count reaches TIMEOUT_CYCLES: pulse `rdid_err` and go to IDLE.
  - On abort, `rdid` and `rdid_match` keep their previous values.
- **`get_rdid` while busy:** ignored. The current frame continues.
- **`get_rdid` and `rise` in the same cycle in IDLE:** the frame starts and that rise is not counted.
- **`reset`** has priority over everything, including mid-frame. It forces IDLE and clears the counters and shift register.
- **Reset values:** `rdid=0`, `rdid_valid=0`, `rdid_match=0`, `rdid_err=0`, `busy=0`, `spiclk_q=0`.
- **Widths:**
  - Bit counter: `$clog2(max(CMD_BITS, N)+1)` bits.
  - Watchdog: `$clog2(TIMEOUT_CYCLES+1)` bits, saturating.

## Timing

- `get_rdid` high at edge t, so `busy=1` from t+1.
- Each SPI bit is 2 clk cycles, so a full frame is (CMD_BITS+N)=32 rises, about 64 clk cycles.
- `rdid_valid` is high in the cycle after the clk edge that processes the 32nd rise. `busy=0` in that same cycle.
- Latency from the last SPICLK rise to `rdid_valid` is 1 clk cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure

- Shared package `spi_pkg` holds:
  - `RDID_OPCODE` = 8'h9F
  - `M25P16_JEDEC_ID` = 24'h202015, which is the default for EXPECTED_ID
  - the state enum {IDLE, SKIP, CAPTURE}
  - SPI mode constants shared with `spi_master`
- One sub-module, `spi_edge_detect`, holds the registered SPICLK and produces the rise and fall pulses. It is reusable by `spi_master`'s checker logic.

## Test plan

1. **Nominal match:** reset 100 ns, pulse `get_rdid`. The M25P16 model returns 0x20, 0x20, 0x15.
   - Required: `rdid_valid` pulses once, `rdid=24'h202015`, `rdid_match=1`, `busy` falls in the same cycle as `rdid_valid`.
2. **Mismatch:** a MISO stub returns 0xEF, 0x40, 0x15.
   - Required: `rdid=24'hEF4015`, `rdid_match=0`, `rdid_valid` pulses once.
3. **Retrigger ignored:** a second `get_rdid` during bit 12.
   - Required: a single `rdid_valid` after the 32nd rise, and no restart.
4. **Reset mid-frame:** assert `reset` for one cycle during capture bit 5.
   - Required: next cycle `busy=0`, `rdid=0`, no `rdid_valid`.
   - A subsequent full frame captures 24'h202015 correctly.
5. **Timeout:** stop SPICLK after 10 rises with TIMEOUT_CYCLES=64.
   - Required: `rdid_err` pulses exactly 64 cycles after the last rise, `busy=0`, `rdid` is unchanged from the prior capture.
6. **Idle noise:** toggle SPICLK with MISO=1 for 40 cycles with no `get_rdid`.
   - Required: `busy`, `rdid_valid`, and `rdid_err` all stay 0, and `rdid` is unchanged.
